// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle MIPS board glue: debounce FSM states and LED counter width.
package mips_mc_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } dbnc_state_t;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous board inputs; synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic Reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_button_conditioner.sv
// Single-step button conditioner: synchronize, debounce, one step_pulse per press, LED press counter.
// Optional macro STEP_AUTO_EN adds the auto_run switch and a periodic auto-step generator.
module step_button_conditioner
  import mips_mc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  input  logic                   button_raw,
`ifdef STEP_AUTO_EN
  input  logic                   auto_run,
`endif
  output logic                   step_pulse,
  output logic                   button_level,
  output logic [PRESS_CNT_W-1:0] press_count,
  output dbnc_state_t            state_dbg
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Handshake: step_pulse is a single-cycle strobe with no ready; the control FSM must accept it.
  logic             btn_sync;
  dbnc_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             press_evt;
  logic             step_next;

  sync_2ff u_sync_btn (
    .clk     (clk),
    .Reset_n (Reset_n),
    .d       (button_raw),
    .q       (btn_sync)
  );

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          press_evt  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high returns to PRESSED silently; only a new press from IDLE pulses.
        if (btn_sync) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef STEP_AUTO_EN
  localparam int PCNT_W = $clog2(AUTO_PERIOD);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(AUTO_PERIOD - 1);

  logic              auto_sync;
  logic [PCNT_W-1:0] pcnt;
  logic              auto_evt;

  sync_2ff u_sync_auto (
    .clk     (clk),
    .Reset_n (Reset_n),
    .d       (auto_run),
    .q       (auto_sync)
  );

  assign auto_evt = auto_sync && (pcnt == PCNT_LAST);

  always_ff @(posedge clk) begin
    if (!Reset_n || !auto_sync || auto_evt) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  assign step_next = press_evt | auto_evt;
`else
  assign step_next = press_evt;
`endif

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      step_pulse   <= 1'b0;
      button_level <= 1'b0;
      press_count  <= '0;
    end else begin
      step_pulse   <= step_next;
      button_level <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      if (step_pulse) begin
        press_count <= press_count + PRESS_CNT_W'(1);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_step_button_conditioner.sv
// Directed self-checking bench for step_button_conditioner (DEBOUNCE_CYCLES=4, AUTO_PERIOD=10).
`timescale 1ns/1ps
module tb_step_button_conditioner;
  import mips_mc_pkg::*;

  logic        clk;
  logic        Reset_n;
  logic        button_raw;
`ifdef STEP_AUTO_EN
  logic        auto_run;
`endif
  logic        step_pulse;
  logic        button_level;
  logic [7:0]  press_count;
  dbnc_state_t state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  int dbl_cnt = 0;
  int base_p;
  int base_d;
  logic prev_pulse = 1'b0;

  step_button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_PERIOD     (10)
  ) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .button_raw   (button_raw),
`ifdef STEP_AUTO_EN
    .auto_run     (auto_run),
`endif
    .step_pulse   (step_pulse),
    .button_level (button_level),
    .press_count  (press_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor: counts pulses and pulses wider than one cycle
  always @(negedge clk) begin
    if (step_pulse) begin
      pulse_cnt = pulse_cnt + 1;
      if (prev_pulse) dbl_cnt = dbl_cnt + 1;
    end
    prev_pulse = step_pulse;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    button_raw = 1'b0;
    tick(2);
    Reset_n = 1'b1;
  endtask

  task automatic press();
    button_raw = 1'b1;
    tick(10);
    button_raw = 1'b0;
    tick(10);
  endtask

  initial begin
    Reset_n = 1'b0;
    button_raw = 1'b1;
`ifdef STEP_AUTO_EN
    auto_run = 1'b0;
`endif
    // T1: reset with button held high
    tick(3);
    check("t1_rst_pulse", 32'(step_pulse), 32'd0);
    check("t1_rst_level", 32'(button_level), 32'd0);
    check("t1_rst_count", 32'(press_count), 32'd0);
    check("t1_rst_state", 32'(state_dbg), 32'(IDLE));
    Reset_n = 1'b1;
    tick(6);
    check("t1_pulse_e5", 32'(step_pulse), 32'd0);
    tick(1);
    check("t1_pulse_e6", 32'(step_pulse), 32'd1);
    check("t1_level_e6", 32'(button_level), 32'd1);
    tick(1);
    check("t1_pulse_e7", 32'(step_pulse), 32'd0);
    check("t1_count", 32'(press_count), 32'd1);
    button_raw = 1'b0;
    tick(12);
    check("t1_rel_level", 32'(button_level), 32'd0);
    check("t1_rel_state", 32'(state_dbg), 32'(IDLE));

    // T2: clean press held 20 cycles
    do_reset();
    base_p = pulse_cnt;
    button_raw = 1'b1;
    tick(6);
    check("t2_pulse_e5", 32'(step_pulse), 32'd0);
    tick(1);
    check("t2_pulse_e6", 32'(step_pulse), 32'd1);
    tick(1);
    check("t2_pulse_e7", 32'(step_pulse), 32'd0);
    tick(12);
    check("t2_held_pulses", 32'(pulse_cnt - base_p), 32'd1);
    check("t2_level", 32'(button_level), 32'd1);
    check("t2_count", 32'(press_count), 32'd1);
    button_raw = 1'b0;
    tick(12);

    // T3: press bounce, then release bounce
    do_reset();
    base_p = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      button_raw = 1'b1;
      tick(1);
      button_raw = 1'b0;
      tick(1);
    end
    button_raw = 1'b1;
    tick(3);
    button_raw = 1'b0;
    tick(10);
    check("t3_bounce_pulses", 32'(pulse_cnt - base_p), 32'd0);
    check("t3_bounce_count", 32'(press_count), 32'd0);
    check("t3_bounce_state", 32'(state_dbg), 32'(IDLE));
    button_raw = 1'b1;
    tick(12);
    button_raw = 1'b0;
    tick(2);
    button_raw = 1'b1;
    tick(1);
    button_raw = 1'b0;
    tick(14);
    check("t3_rel_pulses", 32'(pulse_cnt - base_p), 32'd1);
    check("t3_rel_count", 32'(press_count), 32'd1);
    check("t3_rel_state", 32'(state_dbg), 32'(IDLE));

    // T4: 256 presses wrap the counter
    do_reset();
    base_p = pulse_cnt;
    base_d = dbl_cnt;
    for (int i = 0; i < 255; i++) press();
    check("t4_count_255", 32'(press_count), 32'd255);
    press();
    check("t4_count_wrap", 32'(press_count), 32'd0);
    check("t4_pulses", 32'(pulse_cnt - base_p), 32'd256);
    check("t4_wide_pulses", 32'(dbl_cnt - base_d), 32'd0);

    // T5: reset during PRESS_WAIT aborts the press
    do_reset();
    base_p = pulse_cnt;
    button_raw = 1'b1;
    tick(4);
    check("t5_in_press_wait", 32'(state_dbg), 32'(PRESS_WAIT));
    Reset_n = 1'b0;
    tick(2);
    check("t5_abort_state", 32'(state_dbg), 32'(IDLE));
    check("t5_abort_level", 32'(button_level), 32'd0);
    button_raw = 1'b0;
    Reset_n = 1'b1;
    tick(10);
    check("t5_abort_pulses", 32'(pulse_cnt - base_p), 32'd0);
    check("t5_abort_count", 32'(press_count), 32'd0);
    press();
    check("t5_new_pulses", 32'(pulse_cnt - base_p), 32'd1);
    check("t5_new_count", 32'(press_count), 32'd1);

`ifdef STEP_AUTO_EN
    // T6: auto-step period and coincident button pulse
    do_reset();
    base_p = pulse_cnt;
    auto_run = 1'b1;
    tick(35);
    auto_run = 1'b0;
    tick(5);
    check("t6_auto_pulses", 32'(pulse_cnt - base_p), 32'd3);
    check("t6_auto_count", 32'(press_count), 32'd3);
    do_reset();
    base_p = pulse_cnt;
    auto_run = 1'b1;
    tick(5);
    button_raw = 1'b1;
    tick(6);
    check("t6_co_pulse_e10", 32'(step_pulse), 32'd0);
    tick(1);
    check("t6_co_pulse_e11", 32'(step_pulse), 32'd1);
    tick(1);
    check("t6_co_pulse_e12", 32'(step_pulse), 32'd0);
    check("t6_co_count", 32'(press_count), 32'd1);
    auto_run = 1'b0;
    button_raw = 1'b0;
    tick(12);
    check("t6_co_pulses", 32'(pulse_cnt - base_p), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
